// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, port owner, transfer size.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        DMA_BURST = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [3:0] XFER_DW = 4'b1000;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive denied DMA cycles; starve_force pushes DMA ahead of the CPU.
// Only instantiated when DMEM_ARB_STARVE_EN is defined.
module dmem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic starve_force
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_r;

    // Starvation counter: clears whenever DMA is served or stops asking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!dma_req || dma_gnt) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (starve_cnt_r != LIMIT_C) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Force flag decoded straight from the counter register.
    always_comb begin
        starve_force = (starve_cnt_r == LIMIT_C);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the MEM stage and a DMA/loader with locked bursts.
// Optional DMEM_ARB_STARVE_EN bounds DMA starvation under continuous CPU traffic.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int BURST_MAX    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_xfer_size,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BEAT_W = $clog2(BURST_MAX + 1);
    localparam logic [BEAT_W-1:0] BURST_MAX_C = BEAT_W'(BURST_MAX);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [BEAT_W-1:0] beat_cnt_r;
    logic [BEAT_W-1:0] beat_cnt_nxt_s;
    owner_e            owner_s;
    logic              cpu_grant_s;
    logic              dma_grant_s;
    logic              starve_force_s;
    logic              dma_rvalid_r;
    logic [DATA_W-1:0] dma_rdata_r;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .dma_req     (dma_req),
        .dma_gnt     (dma_grant_s),
        .starve_force(starve_force_s)
    );
`else
    assign starve_force_s = 1'b0;
`endif

    // Arbitration and burst lock: picks the owner and the next state/beat count.
    always_comb begin
        state_nxt_s    = state_r;
        beat_cnt_nxt_s = beat_cnt_r;
        owner_s        = OWN_NONE;
        if (!rst) begin
            owner_s = OWN_NONE;
        end else begin
            case (state_r)
                IDLE: begin
                    // Force only matters while DMA is actually waiting; otherwise the CPU is never blocked.
                    if (cpu_req && !(starve_force_s && dma_req)) begin
                        owner_s = OWN_CPU;
                    end else if (dma_req) begin
                        owner_s = OWN_DMA;
                        if (!dma_last) begin
                            state_nxt_s    = DMA_BURST;
                            beat_cnt_nxt_s = BEAT_W'(1);
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        owner_s = OWN_NONE;
                    end
                end
                DMA_BURST: begin
                    if (dma_req) begin
                        owner_s = OWN_DMA;
                        if (dma_last || (beat_cnt_r + BEAT_W'(1) == BURST_MAX_C)) begin
                            state_nxt_s    = IDLE;
                            beat_cnt_nxt_s = {BEAT_W{1'b0}};
                        end else begin
                            beat_cnt_nxt_s = beat_cnt_r + BEAT_W'(1);
                        end
                    end else begin
                        state_nxt_s    = IDLE;
                        beat_cnt_nxt_s = {BEAT_W{1'b0}};
                    end
                end
                default: begin
                    state_nxt_s    = IDLE;
                    beat_cnt_nxt_s = {BEAT_W{1'b0}};
                end
            endcase
        end
    end

    // Grant decode and memory port mux; CPU values sit on the bus when nobody is granted.
    always_comb begin
        cpu_grant_s   = (owner_s == OWN_CPU);
        dma_grant_s   = (owner_s == OWN_DMA);
        cpu_stall     = rst & cpu_req & ~cpu_grant_s;
        dma_gnt       = dma_grant_s;
        mem_addr      = dma_grant_s ? dma_addr  : cpu_addr;
        mem_wdata     = dma_grant_s ? dma_wdata : cpu_wdata;
        mem_we        = (cpu_grant_s & cpu_we)  | (dma_grant_s & dma_we);
        mem_re        = (cpu_grant_s & ~cpu_we) | (dma_grant_s & ~dma_we);
        mem_xfer_size = XFER_DW;
        cpu_rdata     = mem_rdata;
        dma_rvalid    = dma_rvalid_r;
        dma_rdata     = dma_rdata_r;
    end

    // State, beat counter and registered DMA read return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            beat_cnt_r   <= {BEAT_W{1'b0}};
            dma_rvalid_r <= 1'b0;
            dma_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
            dma_rvalid_r <= dma_grant_s & ~dma_we;
            if (dma_grant_s && !dma_we) begin
                dma_rdata_r <= mem_rdata;
            end else begin
                dma_rdata_r <= dma_rdata_r;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we, dma_last;
    logic [63:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic [3:0]  mem_xfer_size;

    logic [63:0] mem_arr [0:31];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr[7:3]];

    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr[7:3]] = mem_wdata;
    end

    dmem_arbiter #(
        .ADDR_W(64), .DATA_W(64), .BURST_MAX(8), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
        .mem_xfer_size(mem_xfer_size), .mem_rdata(mem_rdata)
    );

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 64'h0; cpu_wdata = 64'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 64'h0; dma_wdata = 64'h0; dma_last = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        cpu_req = 1'b1; dma_req = 1'b1; dma_last = 1'b0;
        #1;
        total++; if (dma_gnt !== 1'b0)     begin bad++; $display("FAIL reset_dma_gnt: got %b want 0", dma_gnt); end
        total++; if (cpu_stall !== 1'b0)   begin bad++; $display("FAIL reset_cpu_stall: got %b want 0", cpu_stall); end
        total++; if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL reset_mem_en: got %b want 00", {mem_we, mem_re}); end
        total++; if (dma_rvalid !== 1'b0)  begin bad++; $display("FAIL reset_rvalid: got %b want 0", dma_rvalid); end
        total++; if (dma_rdata !== 64'h0)  begin bad++; $display("FAIL reset_rdata: got %h want 0", dma_rdata); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_store_load();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h10; cpu_wdata = 64'hDEADBEEF;
        #1;
        total++; if (mem_we !== 1'b1)        begin bad++; $display("FAIL store_mem_we: got %b want 1", mem_we); end
        total++; if (cpu_stall !== 1'b0)     begin bad++; $display("FAIL store_stall: got %b want 0", cpu_stall); end
        total++; if (mem_addr !== 64'h10)    begin bad++; $display("FAIL store_addr: got %h want 10", mem_addr); end
        total++; if (mem_wdata !== 64'hDEADBEEF) begin bad++; $display("FAIL store_wdata: got %h want deadbeef", mem_wdata); end
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        total++; if ({mem_re, mem_we} !== 2'b10) begin bad++; $display("FAIL load_mem_en: got %b want 10", {mem_re, mem_we}); end
        total++; if (cpu_rdata !== 64'hDEADBEEF) begin bad++; $display("FAIL load_rdata: got %h want deadbeef", cpu_rdata); end
        total++; if (cpu_stall !== 1'b0)     begin bad++; $display("FAIL load_stall: got %b want 0", cpu_stall); end
        total++; if (mem_xfer_size !== 4'b1000) begin bad++; $display("FAIL xfer_size: got %b want 1000", mem_xfer_size); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_dma_burst();
        int stall_cycles = 0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 64'h40 + 64'(b * 8); dma_last = (b == 3);
            cpu_req = (b >= 1); cpu_we = 1'b0; cpu_addr = 64'h20;
            #1;
            if (cpu_stall === 1'b1) stall_cycles++;
            total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL burst_gnt beat%0d: got %b want 1", b, dma_gnt); end
            total++; if (mem_addr !== 64'h40 + 64'(b * 8)) begin
                bad++; $display("FAIL burst_addr beat%0d: got %h want %h", b, mem_addr, 64'h40 + 64'(b * 8));
            end
            if (b > 0) begin
                total++; if (dma_rvalid !== 1'b1) begin bad++; $display("FAIL burst_rvalid beat%0d: got %b want 1", b, dma_rvalid); end
                total++; if (dma_rdata !== {32'hA5A5_0000, 32'(7 + b)}) begin
                    bad++; $display("FAIL burst_rdata beat%0d: got %h want %h", b, dma_rdata, {32'hA5A5_0000, 32'(7 + b)});
                end
            end
        end
        @(negedge clk);
        dma_req = 1'b0; dma_last = 1'b0;
        #1;
        total++; if (stall_cycles != 3)      begin bad++; $display("FAIL burst_stall_count: got %0d want 3", stall_cycles); end
        total++; if (cpu_stall !== 1'b0)     begin bad++; $display("FAIL burst_cpu_after: got stall %b want 0", cpu_stall); end
        total++; if (mem_addr !== 64'h20)    begin bad++; $display("FAIL burst_cpu_addr: got %h want 20", mem_addr); end
        total++; if (cpu_rdata !== 64'hA5A5_0000_0000_0004) begin bad++; $display("FAIL burst_cpu_rdata: got %h want a5a5000000000004", cpu_rdata); end
        total++; if (dma_rvalid !== 1'b1)    begin bad++; $display("FAIL burst_last_rvalid: got %b want 1", dma_rvalid); end
        total++; if (dma_rdata !== 64'hA5A5_0000_0000_000B) begin bad++; $display("FAIL burst_last_rdata: got %h want a5a500000000000b", dma_rdata); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (dma_rvalid !== 1'b0)    begin bad++; $display("FAIL burst_rvalid_drop: got %b want 0", dma_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_burst_max();
        for (int b = 0; b < 9; b++) begin
            @(negedge clk);
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 64'h80 + 64'(b * 8);
            dma_wdata = 64'hB000 + 64'(b); dma_last = 1'b0;
            cpu_req = (b >= 1); cpu_we = 1'b0; cpu_addr = 64'h20;
            #1;
            if (b < 8) begin
                total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL bmax_gnt beat%0d: got %b want 1", b, dma_gnt); end
                total++; if (cpu_stall !== (b >= 1)) begin bad++; $display("FAIL bmax_stall beat%0d: got %b want %b", b, cpu_stall, (b >= 1)); end
            end else begin
                total++; if (dma_gnt !== 1'b0)   begin bad++; $display("FAIL bmax_release_gnt: got %b want 0", dma_gnt); end
                total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL bmax_release_stall: got %b want 0", cpu_stall); end
                total++; if ({mem_re, mem_we} !== 2'b10) begin bad++; $display("FAIL bmax_cpu_read: got %b want 10", {mem_re, mem_we}); end
            end
        end
        @(negedge clk);
        idle_inputs();
        total++; if (mem_arr[23] !== 64'hB007) begin bad++; $display("FAIL bmax_beat8_write: got %h want b007", mem_arr[23]); end
        total++; if (mem_arr[24] !== 64'hA5A5_0000_0000_0018) begin bad++; $display("FAIL bmax_no_beat9: got %h want a5a5000000000018", mem_arr[24]); end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic exp_gnt;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h20;
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 64'hF8; dma_wdata = 64'hC0FFEE; dma_last = 1'b1;
`ifdef DMEM_ARB_STARVE_EN
            exp_gnt = (c == 4);
`else
            exp_gnt = 1'b0;
`endif
            #1;
            total++; if (dma_gnt !== exp_gnt)   begin bad++; $display("FAIL starve_gnt cyc%0d: got %b want %b", c, dma_gnt, exp_gnt); end
            total++; if (cpu_stall !== exp_gnt) begin bad++; $display("FAIL starve_stall cyc%0d: got %b want %b", c, cpu_stall, exp_gnt); end
        end
        @(negedge clk);
        idle_inputs();
`ifdef DMEM_ARB_STARVE_EN
        total++; if (mem_arr[31] !== 64'hC0FFEE) begin bad++; $display("FAIL starve_write: got %h want c0ffee", mem_arr[31]); end
`else
        total++; if (mem_arr[31] !== 64'hA5A5_0000_0000_001F) begin bad++; $display("FAIL starve_nowrite: got %h want a5a500000000001f", mem_arr[31]); end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 64'h40; dma_last = 1'b0; cpu_req = 1'b0;
        #1;
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_beat1_gnt: got %b want 1", dma_gnt); end
        @(negedge clk);
        dma_addr = 64'h48; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h20; rst = 1'b0;
        #1;
        total++; if (dma_gnt !== 1'b0)     begin bad++; $display("FAIL rstmid_gnt: got %b want 0", dma_gnt); end
        total++; if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL rstmid_mem_en: got %b want 00", {mem_we, mem_re}); end
        total++; if (cpu_stall !== 1'b0)   begin bad++; $display("FAIL rstmid_stall: got %b want 0", cpu_stall); end
        total++; if (dma_rvalid !== 1'b0)  begin bad++; $display("FAIL rstmid_rvalid: got %b want 0", dma_rvalid); end
        total++; if (dma_rdata !== 64'h0)  begin bad++; $display("FAIL rstmid_rdata: got %h want 0", dma_rdata); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (dma_gnt !== 1'b0)     begin bad++; $display("FAIL rstrel_gnt: got %b want 0", dma_gnt); end
        total++; if (cpu_stall !== 1'b0)   begin bad++; $display("FAIL rstrel_stall: got %b want 0", cpu_stall); end
        total++; if (mem_addr !== 64'h20)  begin bad++; $display("FAIL rstrel_addr: got %h want 20", mem_addr); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_dma_drop();
        @(negedge clk);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 64'h40; dma_last = 1'b0; cpu_req = 1'b0;
        #1;
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL drop_beat1_gnt: got %b want 1", dma_gnt); end
        @(negedge clk);
        dma_addr = 64'h48; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h20;
        #1;
        total++; if ({dma_gnt, cpu_stall} !== 2'b11) begin bad++; $display("FAIL drop_beat2: got gnt,stall=%b want 11", {dma_gnt, cpu_stall}); end
        @(negedge clk);
        dma_req = 1'b0;
        #1;
        total++; if (dma_gnt !== 1'b0)   begin bad++; $display("FAIL drop_release_gnt: got %b want 0", dma_gnt); end
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL drop_release_stall: got %b want 1", cpu_stall); end
        total++; if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL drop_release_mem: got %b want 00", {mem_we, mem_re}); end
        @(negedge clk);
        #1;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL drop_cpu_grant: got stall %b want 0", cpu_stall); end
        total++; if ({mem_re, mem_addr} !== {1'b1, 64'h20}) begin bad++; $display("FAIL drop_cpu_access: got re=%b addr=%h want re=1 addr=20", mem_re, mem_addr); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 32; i++) mem_arr[i] = {32'hA5A5_0000, 32'(i)};
        test_reset();
        test_cpu_store_load();
        test_dma_burst();
        test_burst_max();
        test_starvation();
        test_reset_mid_burst();
        test_dma_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the pipeline MEM stage and a DMA/loader requester. Sits between the EX/MEM pipeline register outputs and the data memory. Grants one access per cycle and stalls the pipeline when the CPU loses arbitration. Supports locked DMA bursts and bounded DMA starvation.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- BURST_MAX, 8, maximum beats in one locked DMA burst (≥2)
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA is forced ahead of CPU (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  MEM stage access (memRead_MEM | memWrite_MEM)
- cpu_we  in  1  1 = store
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  store data
- cpu_stall  out  1  freeze PC and all pipeline registers; CPU holds request
- cpu_rdata  out  DATA_W  load data, combinational from memory in grant cycle
- dma_req  in  1  DMA beat request
- dma_we  in  1  1 = write
- dma_addr  in  ADDR_W  byte address
- dma_wdata  in  DATA_W  write data
- dma_last  in  1  final beat of burst (single-beat = dma_last high)
- dma_gnt  out  1  beat accepted this cycle
- dma_rvalid  out  1  registered read data valid
- dma_rdata  out  DATA_W  registered read data
- mem_addr  out  ADDR_W  to datamem address
- mem_we  out  1  to datamem write_enable
- mem_re  out  1  to datamem read_enable
- mem_wdata  out  DATA_W  to datamem write_data
- mem_xfer_size  out  4  constant 4'b1000 (doubleword)
- mem_rdata  in  DATA_W  from datamem read_data

## Operation
- States: IDLE, DMA_BURST.
- IDLE: if cpu_req and not starve_force → grant CPU. Else if dma_req → grant DMA; if !dma_last → DMA_BURST, beat_cnt=1.
- DMA_BURST: DMA owns the port; CPU never granted. Granted beat with dma_last, or beat_cnt+1 == BURST_MAX → IDLE. dma_req low in DMA_BURST → IDLE same edge (lock released, no grant).
- beat_cnt increments on every granted DMA beat in DMA_BURST.
- cpu_stall = cpu_req & !cpu_grant. dma_gnt = DMA granted.
- Memory mux: mem_addr/mem_wdata from granted requester; mem_we = grant & we; mem_re = grant & !we. No grant → mem_we=mem_re=0, mem_addr/mem_wdata = CPU values.
- cpu_rdata = mem_rdata always; meaningful only when cpu_req & !cpu_we & !cpu_stall.
- starve_cnt: +1 each cycle dma_req & !dma_gnt; cleared on dma_gnt or !dma_req; saturates at STARVE_LIMIT. starve_force = (starve_cnt == STARVE_LIMIT).
- Simultaneous cpu_req & dma_req in IDLE: CPU wins unless starve_force.

## Timing
- Reset (rst low): state IDLE, beat_cnt=0, starve_cnt=0, dma_rvalid=0, dma_rdata=0; while rst low dma_gnt=0, cpu_stall=0, mem_we=mem_re=0, regardless of requests.
- Reset mid-burst: burst aborted; first cycle after release is IDLE arbitration.
- CPU access: zero added latency when granted; each stalled cycle delays it by one cycle.
- DMA read: dma_rvalid/dma_rdata registered, asserted exactly one cycle after the granted read beat, for one cycle.
- Worst-case CPU stall: BURST_MAX cycles per burst.
- Worst-case DMA wait: STARVE_LIMIT+1 cycles under continuous CPU traffic.

## Configuration
- DMEM_ARB_STARVE_EN defined: starvation counter and starve_force active as above.
- Not defined: starve_cnt absent, starve_force tied 0; strict CPU priority in IDLE (DMA may starve indefinitely).

## Structure
- Package dmem_arb_pkg: state enum (IDLE, DMA_BURST), owner enum (OWN_NONE, OWN_CPU, OWN_DMA), XFER_DW = 4'b1000.
- Sub-module dmem_arb_starve_ctr: saturating starvation counter producing starve_force; instantiated only under DMEM_ARB_STARVE_EN.

## Test plan
- CPU store then load, addr 0x10, data 0xDEADBEEF, no DMA → mem_we pulse then cpu_rdata=0xDEADBEEF in load cycle; cpu_stall never high.
- DMA 4-beat read burst from 0x40 with cpu_req held from beat 2 → dma_gnt 4 consecutive cycles, cpu_stall high 3 cycles, CPU granted on 5th cycle; dma_rvalid lags each beat by 1.
- DMA burst without dma_last, BURST_MAX=8 → forced return to IDLE after 8th beat; CPU granted next cycle.
- Continuous cpu_req and dma_req, STARVE_LIMIT=4, macro defined → DMA granted on 5th cycle; macro undefined → dma_gnt never asserts.
- rst low during beat 2 of a burst → dma_rvalid=0, dma_gnt=0, mem_we=mem_re=0 immediately; after release CPU wins simultaneous request.
- dma_req dropped mid-burst → state IDLE next cycle, pending cpu_req granted in that cycle.
